// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: access size encoding, arbiter
// state, grant owner, and the misalignment test used when MISALIGN_TRAP_EN
// is defined.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_REQ  = 2'b01,
        ARB_RSP  = 2'b10,
        ARB_DONE = 2'b11
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } arb_grant_t;

    // A halfword must sit on an even address and a word on a multiple of four.
    // Any size other than BYTE/HALF_WORD is handled as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            BYTE:      mis = 1'b0;
            HALF_WORD: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lane.sv
// mem_lane_align: combinational byte-lane steering for the arbiter.
// Store side turns size/address/data into strobes and lane-replicated data;
// load side picks the addressed lane out of the read word and extends it.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic        zext,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store strobes and replicated write data; unknown sizes act as WORD
    always_comb begin
        wstrb     = 4'h0;
        wdata_rep = 32'h0000_0000;
        case (size)
            BYTE: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            HALF_WORD: begin
                wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                wstrb     = 4'hF;
                wdata_rep = wdata;
            end
        endcase
    end

    // Select the addressed byte and halfword lanes of the read word
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Zero- or sign-extend the selected lane
    always_comb begin
        ld_data = 32'h0000_0000;
        case (size)
            BYTE:      ld_data = zext ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            HALF_WORD: ld_data = zext ? {16'h0000, half_s}    : {{16{half_s[15]}}, half_s};
            default:   ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the load/store path, one transaction in flight at a time.
// D has priority except when IF has waited through STARVE_MAX D grants.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned D accesses
// (granted, no memory access, d_misalign reported) instead of ignoring the
// offending low address bits.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_req_valid,
    input  logic        d_req_write,
    input  logic [1:0]  d_req_size,
    input  logic        d_req_zext,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_misalign,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_wstrb,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata
);

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state_q, state_d;
    arb_grant_t       gnt_q, gnt_d;
    logic             write_q, write_d;
    logic [1:0]       size_q, size_d;
    logic             zext_q, zext_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             mem_req_valid_q, mem_req_valid_d;
    logic             mem_req_write_q, mem_req_write_d;
    logic [31:0]      mem_req_addr_q, mem_req_addr_d;
    logic [3:0]       mem_req_wstrb_q, mem_req_wstrb_d;
    logic [31:0]      mem_req_wdata_q, mem_req_wdata_d;
    logic             if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0]      if_rsp_data_q, if_rsp_data_d;
    logic             d_rsp_valid_q, d_rsp_valid_d;
    logic [31:0]      d_rsp_data_q, d_rsp_data_d;
    logic             d_misalign_q, d_misalign_d;

    logic             win_if_s, win_d_s, trap_s;
    logic [1:0]       al_size_s, al_lo_s;
    logic [3:0]       al_wstrb_s;
    logic [31:0]      al_wdata_s, al_ld_s;
    logic             unused_s;

    // Fetch addresses are word addresses; their low bits carry no meaning
    assign unused_s = ^if_req_addr[1:0];

    // Arbitration in IDLE: D wins unless IF has been starved to the limit
    always_comb begin
        win_d_s  = 1'b0;
        win_if_s = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (d_req_valid && !(if_req_valid && (starve_q == STARVE_LIM))) begin
                win_d_s = 1'b1;
            end else if (if_req_valid) begin
                win_if_s = 1'b1;
            end else begin
                win_d_s  = 1'b0;
                win_if_s = 1'b0;
            end
        end else begin
            win_d_s  = 1'b0;
            win_if_s = 1'b0;
        end
    end

    assign if_req_ready = win_if_s;
    assign d_req_ready  = win_d_s;

`ifdef MISALIGN_TRAP_EN
    assign trap_s = win_d_s && is_misaligned(d_req_size, d_req_addr[1:0]);
`else
    assign trap_s = 1'b0;
`endif

    // The lane aligner sees the live request at grant time and the captured
    // request afterwards, when only its load-extract half matters
    assign al_size_s = (state_q == ARB_IDLE) ? d_req_size       : size_q;
    assign al_lo_s   = (state_q == ARB_IDLE) ? d_req_addr[1:0]  : addr_lo_q;

    mem_lane_align u_lane (
        .size      (al_size_s),
        .addr_lo   (al_lo_s),
        .wdata     (d_req_wdata),
        .zext      (zext_q),
        .rdata     (mem_rsp_rdata),
        .wstrb     (al_wstrb_s),
        .wdata_rep (al_wdata_s),
        .ld_data   (al_ld_s)
    );

    // Starvation counter: counts D grants that bypass a waiting IF
    always_comb begin
        starve_d = starve_q;
        if (win_if_s) begin
            starve_d = '0;
        end else if (win_d_s && if_req_valid) begin
            if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + CNT_W'(1);
            end else begin
                starve_d = starve_q;
            end
        end else if ((state_q == ARB_IDLE) && !if_req_valid) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q;
        end
    end

    // Transaction FSM with request capture and response pulse generation
    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        write_d         = write_q;
        size_d          = size_q;
        zext_d          = zext_q;
        addr_lo_d       = addr_lo_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_write_d = mem_req_write_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wstrb_d = mem_req_wstrb_q;
        mem_req_wdata_d = mem_req_wdata_q;
        if_rsp_valid_d  = 1'b0;
        if_rsp_data_d   = if_rsp_data_q;
        d_rsp_valid_d   = 1'b0;
        d_rsp_data_d    = d_rsp_data_q;
        d_misalign_d    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (win_d_s) begin
                    gnt_d     = GNT_D;
                    write_d   = d_req_write;
                    size_d    = d_req_size;
                    zext_d    = d_req_zext;
                    addr_lo_d = d_req_addr[1:0];
                    if (trap_s) begin
                        state_d       = ARB_DONE;
                        d_rsp_valid_d = 1'b1;
                        d_misalign_d  = 1'b1;
                        d_rsp_data_d  = 32'h0000_0000;
                    end else begin
                        state_d         = ARB_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_req_write_d = d_req_write;
                        mem_req_addr_d  = {d_req_addr[31:2], 2'b00};
                        mem_req_wstrb_d = d_req_write ? al_wstrb_s : 4'h0;
                        mem_req_wdata_d = d_req_write ? al_wdata_s : 32'h0000_0000;
                    end
                end else if (win_if_s) begin
                    gnt_d           = GNT_IF;
                    write_d         = 1'b0;
                    state_d         = ARB_REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_write_d = 1'b0;
                    mem_req_addr_d  = {if_req_addr[31:2], 2'b00};
                    mem_req_wstrb_d = 4'h0;
                    mem_req_wdata_d = 32'h0000_0000;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_REQ: begin
                if (mem_req_ready) begin
                    state_d         = ARB_RSP;
                    mem_req_valid_d = 1'b0;
                end else begin
                    state_d = ARB_REQ;
                end
            end
            ARB_RSP: begin
                if (mem_rsp_valid) begin
                    state_d = ARB_DONE;
                    if (gnt_q == GNT_IF) begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_data_d  = mem_rsp_rdata;
                    end else begin
                        d_rsp_valid_d = 1'b1;
                        d_rsp_data_d  = write_q ? 32'h0000_0000 : al_ld_s;
                    end
                end else begin
                    state_d = ARB_RSP;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ARB_IDLE;
            gnt_q           <= GNT_IF;
            write_q         <= 1'b0;
            size_q          <= 2'b00;
            zext_q          <= 1'b0;
            addr_lo_q       <= 2'b00;
            starve_q        <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= 32'h0000_0000;
            mem_req_wstrb_q <= 4'h0;
            mem_req_wdata_q <= 32'h0000_0000;
            if_rsp_valid_q  <= 1'b0;
            if_rsp_data_q   <= 32'h0000_0000;
            d_rsp_valid_q   <= 1'b0;
            d_rsp_data_q    <= 32'h0000_0000;
            d_misalign_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            write_q         <= write_d;
            size_q          <= size_d;
            zext_q          <= zext_d;
            addr_lo_q       <= addr_lo_d;
            starve_q        <= starve_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_write_q <= mem_req_write_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wstrb_q <= mem_req_wstrb_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            if_rsp_valid_q  <= if_rsp_valid_d;
            if_rsp_data_q   <= if_rsp_data_d;
            d_rsp_valid_q   <= d_rsp_valid_d;
            d_rsp_data_q    <= d_rsp_data_d;
            d_misalign_q    <= d_misalign_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_write = mem_req_write_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wstrb = mem_req_wstrb_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_data   = if_rsp_data_q;
    assign d_rsp_valid   = d_rsp_valid_q;
    assign d_rsp_data    = d_rsp_data_q;
    assign d_misalign    = d_misalign_q;

endmodule
